// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file defaults and soft-clear state encoding
package cpu_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    typedef enum logic {IDLE, SWEEP} clr_state_e;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: soft-clear sequencer sweeping addresses 0..DEPTH-1, one per cycle
module regfile_clr_seq
    import cpu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    // Sweep FSM: requests are only honoured in IDLE; SWEEP runs exactly DEPTH cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (state_q == IDLE) begin
            if (clr_req) begin
                state_q <= SWEEP;
                cnt_q   <= '0;
            end
        end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_q <= IDLE;
        end
    end
    assign clr_busy = (state_q == SWEEP);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with bypass, pending scoreboard and soft clear
module regfile_param
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              clr_req,
    output logic              clr_busy
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              clr_we, wr_ok, rsv_ok, z_a, z_b;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok  = wr_en && !clr_busy && !(R0_ZERO != 0 && wr_addr == '0);
    assign rsv_ok = rsv_en && !clr_busy && !(R0_ZERO != 0 && rsv_addr == '0);
    assign z_a    = (R0_ZERO != 0) && (rd_addr_a == '0);
    assign z_b    = (R0_ZERO != 0) && (rd_addr_b == '0);

    // Next state: sweep clear, else write then reserve so a same-edge reserve leaves the entry pending
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (clr_we) begin
            mem_d[clr_addr]  = '0;
            pend_d[clr_addr] = 1'b0;
        end
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    end

    // Storage and scoreboard registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Read ports: zero register overrides bypass; bypass only sees accepted writes
    always_comb begin
        rd_data_a = z_a ? '0 : (BYPASS != 0 && wr_ok && wr_addr == rd_addr_a) ? wr_data : mem_q[rd_addr_a];
        rd_data_b = z_b ? '0 : (BYPASS != 0 && wr_ok && wr_addr == rd_addr_b) ? wr_data : mem_q[rd_addr_b];
        pend_a    = z_a ? 1'b0 : pend_q[rd_addr_a];
        pend_b    = z_b ? 1'b0 : pend_q[rd_addr_b];
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of two configurations (bypass/no-zero and no-bypass/zero-r0)
module tb_regfile_param;
    logic       clk = 1'b0, reset = 1'b1;
    logic       wr_en = 1'b0, rsv_en = 1'b0, clr_req = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, rsv_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_a_x, rd_b_x, rd_a_y, rd_b_y;
    logic       pa_x, pb_x, busy_x, pa_y, pb_y, busy_y;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    regfile_param #(.R0_ZERO(0), .BYPASS(1)) u_x (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a_x), .rd_data_b(rd_b_x),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_a(pa_x), .pend_b(pb_x),
        .clr_req(clr_req), .clr_busy(busy_x)
    );

    regfile_param #(.R0_ZERO(1), .BYPASS(0)) u_y (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a_y), .rd_data_b(rd_b_y),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_a(pa_y), .pend_b(pb_y),
        .clr_req(clr_req), .clr_busy(busy_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        // 1: reset with garbage inputs, then release
        #1 reset = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hEE; rsv_en = 1'b1; rsv_addr = 3'd1; clr_req = 1'b1;
        rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        step(); step();
        chk("rst_busy_x", busy_x, 0);
        chk("rst_rd_a_x", rd_a_x, 8'h00);
        chk("rst_pend_a_x", pa_x, 0);
        idle_in();
        @(negedge clk) reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i); #1;
            chk($sformatf("post_rst_x_r%0d", i), rd_a_x, 8'h00);
            chk($sformatf("post_rst_y_r%0d", i), rd_b_y, 8'h00);
            chk($sformatf("post_rst_pend_r%0d", i), {pa_x, pb_y}, 2'b00);
        end
        chk("post_rst_busy", {busy_x, busy_y}, 2'b00);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        step();
        idle_in(); rd_addr_a = 3'd3; #1;
        chk("wr_r3_x", rd_a_x, 8'hA5);
        chk("wr_r3_y", rd_a_y, 8'hA5);
        // 2: bypass vs no bypass
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; rd_addr_a = 3'd5; #1;
        chk("byp_same_x", rd_a_x, 8'h3C);
        chk("nobyp_same_y", rd_a_y, 8'h00);
        step();
        idle_in(); #1;
        chk("byp_next_x", rd_a_x, 8'h3C);
        chk("nobyp_next_y", rd_a_y, 8'h3C);
        // 3: register zero
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 3'd0; rd_addr_a = 3'd0; #1;
        chk("r0_byp_x", rd_a_x, 8'hFF);
        chk("r0_zero_byp_y", rd_a_y, 8'h00);
        step();
        idle_in(); #1;
        chk("r0_x", rd_a_x, 8'hFF);
        chk("r0_pend_x", pa_x, 1);
        chk("r0_y", rd_a_y, 8'h00);
        chk("r0_pend_y", pa_y, 0);
        // 4: scoreboard
        rsv_en = 1'b1; rsv_addr = 3'd2; rd_addr_a = 3'd2; rd_addr_b = 3'd2; #1;
        chk("rsv_no_byp", {pa_x, pa_y}, 2'b00);
        step();
        idle_in(); #1;
        chk("rsv_pend_a", {pa_x, pa_y}, 2'b11);
        chk("rsv_pend_b", {pb_x, pb_y}, 2'b11);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
        step();
        idle_in(); #1;
        chk("wr_clr_pend", {pa_x, pa_y}, 2'b00);
        chk("wr_r2_y", rd_a_y, 8'h11);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h22; rsv_en = 1'b1; rsv_addr = 3'd2;
        step();
        idle_in(); #1;
        chk("wr_rsv_data", {rd_a_x, rd_a_y}, 16'h2222);
        chk("wr_rsv_pend", {pa_x, pa_y}, 2'b11);
        // 5: fill then soft clear
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i + 1);
            step();
        end
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd7;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h77; #1;
        chk("sw_busy0", {busy_x, busy_y}, 2'b11);
        chk("sw_r0_pre", rd_a_x, 8'h01);
        chk("sw_no_byp_r7", rd_b_x, 8'h08);
        step();
        wr_en = 1'b0; #1;
        chk("sw_r0_cleared", rd_a_x, 8'h00);
        chk("sw_r7_kept", rd_b_x, 8'h08);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("sw_busy_%0d", i), {busy_x, busy_y}, (i < 6) ? 2'b11 : 2'b00);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i); #1;
            chk($sformatf("sw_done_r%0d", i), {rd_a_x, rd_b_y}, 16'h0000);
            chk($sformatf("sw_done_pend_r%0d", i), {pa_x, pb_y}, 2'b00);
        end
        // 6: reset mid-sweep, then restart from r0
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h40 + i);
            step();
        end
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(); step(); step();
        reset = 1'b0; #1;
        chk("mid_rst_busy", {busy_x, busy_y}, 2'b00);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i); #1;
            chk($sformatf("mid_rst_r%0d", i), {rd_a_x, rd_b_y}, 16'h0000);
        end
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h31 + i);
            step();
        end
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
        step(); #1;
        chk("restart_r0", rd_a_x, 8'h00);
        chk("restart_r1", {rd_b_x, rd_b_y}, 16'h3232);
        begin
            int n = 0;
            while (busy_x && n < 20) begin
                step();
                n++;
            end
            chk("restart_len", n, 7);
        end
        chk("restart_idle", {busy_x, busy_y}, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised general-purpose register file for the CPU datapath. Generalises the fixed 8x8 register file in three ways:
- configurable width and depth;
- an optional hard-wired zero register and optional write-to-read bypass;
- a per-register pending (scoreboard) bit, plus a sequenced soft-clear engine.
Sits between the decode/control unit (reserve, read) and the ALU/memory writeback (write).

Parameters:
DATA_W, 8, register width in bits
DEPTH, 8, number of registers; power of two, minimum 2
ADDR_W, $clog2(DEPTH), address width; derived, do not override
R0_ZERO, 0, 1 = register 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock; rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe (LdReg equivalent)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
rsv_en  in  1  mark register rsv_addr pending (result outstanding)
rsv_addr  in  ADDR_W  register to reserve
pend_a  out  1  pending bit of rd_addr_a (combinational)
pend_b  out  1  pending bit of rd_addr_b (combinational)
clr_req  in  1  start soft clear of all registers
clr_busy  out  1  soft clear in progress

Behaviour:
Reset (reset=0, asynchronous):
- All registers and pending bits cleared to 0.
- FSM goes to IDLE; clear counter goes to 0; clr_busy=0.
- Reset asserted mid-sweep aborts the sweep immediately.

Reads:
- rd_data_x = regfile[rd_addr_x]; zero-latency combinational.
- BYPASS=1 and wr_en=1, wr_addr==rd_addr_x, write accepted this cycle: rd_data_x=wr_data.
- BYPASS=0: written value is visible the cycle after the write edge.
- R0_ZERO=1 and rd_addr_x==0: rd_data_x=0 and pend_x=0, overriding bypass.

Writes:
- On the clk rising edge, when wr_en=1 and the FSM is IDLE: regfile[wr_addr]<=wr_data and pending[wr_addr]<=0.
- R0_ZERO=1 and wr_addr==0: write dropped.

Reserve:
- On the clk rising edge, when rsv_en=1 and the FSM is IDLE: pending[rsv_addr]<=1.
- Same-edge write and reserve to the same address: data is written, pending ends at 1 (new producer wins).
- R0_ZERO=1 and rsv_addr==0: ignored.

pend_x:
- Reflects the registered pending bit; no bypass of same-cycle reserve or write.

Soft clear FSM, states IDLE and SWEEP:
- IDLE, clr_req=1: next state SWEEP; clr_cnt<=0.
- SWEEP, each cycle: regfile[clr_cnt]<=0, pending[clr_cnt]<=0, clr_cnt<=clr_cnt+1.
- SWEEP, when clr_cnt==DEPTH-1: that entry is cleared, then return to IDLE.
- Sweep lasts exactly DEPTH cycles.
- clr_busy=1 exactly while in SWEEP (registered).
- During SWEEP: wr_en, rsv_en and clr_req are ignored and dropped; callers must stall on clr_busy.
- Reads during SWEEP return current contents (partially cleared); bypass is inactive during SWEEP.
- clr_req together with wr_en or rsv_en in IDLE: the write/reserve takes effect on that edge, and the sweep then clears it.
- clr_cnt is ADDR_W bits wide; there is no wrap beyond DEPTH-1.

Decomposition:
- Shared package cpu_pkg: DATA_W/DEPTH defaults and the FSM state enum (IDLE, SWEEP).
- One natural sub-module: regfile_clr_seq (FSM + counter; outputs clr_busy, clr_we, clr_addr).
- Storage, bypass and scoreboard stay in the top module.

Test Plan:
1. Reset low with garbage on inputs, then release: all rd_data=0, all pend=0, clr_busy=0; write 8'hA5 to r3, next cycle read r3 -> 8'hA5.
2. BYPASS=1: wr_en, wr_addr=5, wr_data=8'h3C, rd_addr_a=5 in the same cycle -> rd_data_a=8'h3C that cycle. BYPASS=0: old value that cycle, 8'h3C the next.
3. R0_ZERO=1: write 8'hFF to r0, reserve r0 -> rd r0=0, pend=0. R0_ZERO=0: rd r0=8'hFF.
4. Reserve r2 -> pend_a(r2)=1 next cycle. Write r2 8'h11 -> pend 0. Same-edge reserve+write r2 8'h22 -> data 8'h22, pend 1.
5. Fill r0..r7 with 1..8, pulse clr_req -> clr_busy high 8 cycles. r0 reads 0 after the first sweep edge while r7 still reads 8. Write r7 during the sweep is dropped. Afterwards all registers 0, clr_busy 0.
6. Assert reset mid-sweep (cycle 3): clr_busy=0 immediately and all registers 0. After release, clr_req restarts the sweep from r0.
